// File: rtl/segway_pkg.sv
// Shared types and constants for the Segway power/soft-start sequencer.
package segway_pkg;

    typedef enum logic [2:0] {
        OFF,
        RAMP,
        RUN,
        STOP,
        FAULT
    } seq_state_t;

    localparam logic [7:0] SS_MAX     = 8'hFF;
    localparam int         SS_DIV_DEF = 4;
    localparam int         TF_CNT_DEF = 3;

endpackage

// File: rtl/ss_ramp_cnt.sv
// Soft-start ramp counter: a vld prescaler that steps a saturating
// 8-bit up/down scale once every SS_DIV counted strobes.
import segway_pkg::*;

module ss_ramp_cnt #(
    parameter int SS_DIV = SS_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vld,
    input  logic       up,
    input  logic       dn,
    input  logic       clr_pre,
    output logic [7:0] ss_tmr,
    output logic [7:0] ss_nxt
);

    // SS_DIV=1 still gets a 1-bit prescaler; it simply never leaves 0.
    localparam int              PRE_W    = (SS_DIV > 1) ? $clog2(SS_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SS_DIV - 1);

    logic [PRE_W-1:0] pre;
    logic [PRE_W-1:0] pre_nxt;
    logic             tick;
    logic             step;

    // Next prescaler and scale values; the step only happens on the last prescaler count.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        ss_nxt  = ss_tmr;
        pre_nxt = pre;
        tick    = vld && (up || dn);
        step    = tick && (pre == PRE_LAST);
        if (step) begin
            if (up) begin
                if (ss_tmr != SS_MAX) ss_nxt = ss_tmr + 8'd1;
            end else if (ss_tmr != 8'd0) begin
                ss_nxt = ss_tmr - 8'd1;
            end
        end
        if (clr_pre || step) begin
            pre_nxt = '0;
        end else if (tick) begin
            pre_nxt = pre + 1'b1;
        end
    end

    // Prescaler and scale registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            pre    <= '0;
            ss_tmr <= 8'd0;
        end else begin
            pre    <= pre_nxt;
            ss_tmr <= ss_nxt;
        end
    end

endmodule

// File: rtl/segway_pwr_seq.sv
// Power/soft-start sequencer for the Segway motor-math datapath: ramps
// ss_tmr on power request, ramps down on release, and latches an
// overspeed fault after TF_CNT consecutive too_fast samples.
import segway_pkg::*;

module segway_pwr_seq #(
    parameter int SS_DIV = SS_DIV_DEF,
    parameter int TF_CNT = TF_CNT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pwr_req,
    input  logic       vld,
    input  logic       too_fast,
    input  logic       en_steer_in,
    output logic [7:0] ss_tmr,
    output logic       pwr_up,
    output logic       en_steer,
    output logic       fault,
    output logic       ramp_done
);

    localparam logic [3:0] TF_LAST = 4'(TF_CNT - 1);

    seq_state_t state;
    seq_state_t state_nxt;
    logic [3:0] tf_cnt;
    logic [3:0] tf_cnt_nxt;
    logic [7:0] ss_nxt;
    logic       ovs_active;
    logic       trip;
    logic       up;
    logic       dn;
    logic       clr_pre;

    // A trip pre-empts both the ramp step and a release, so the up step is
    // suppressed on the tripping strobe and the scale holds its value.
    assign ovs_active = (state == RAMP) || (state == RUN);
    assign trip       = ovs_active && vld && too_fast && (tf_cnt == TF_LAST);
    assign up         = (state == RAMP) && pwr_req && !trip;
    assign dn         = ((state == STOP) && !pwr_req) || (state == FAULT);
    assign clr_pre    = (state_nxt != state);
    assign en_steer   = en_steer_in && (state == RUN);

    ss_ramp_cnt #(
        .SS_DIV (SS_DIV)
    ) u_ramp (
        .clk     (clk),
        .rst     (rst),
        .vld     (vld),
        .up      (up),
        .dn      (dn),
        .clr_pre (clr_pre),
        .ss_tmr  (ss_tmr),
        .ss_nxt  (ss_nxt)
    );

    // Next-state decode; RUN/OFF are entered on the edge the scale reaches its end value.
    always_comb begin
        state_nxt = state;
        case (state)
            OFF:   if (pwr_req) state_nxt = RAMP;
            RAMP: begin
                if (trip)                  state_nxt = FAULT;
                else if (!pwr_req)         state_nxt = STOP;
                else if (ss_nxt == SS_MAX) state_nxt = RUN;
            end
            RUN: begin
                if (trip)          state_nxt = FAULT;
                else if (!pwr_req) state_nxt = STOP;
            end
            STOP: begin
                if (pwr_req)             state_nxt = RAMP;
                else if (ss_nxt == 8'd0) state_nxt = OFF;
            end
            FAULT: if ((ss_tmr == 8'd0) && !pwr_req) state_nxt = OFF;
            default: state_nxt = OFF;
        endcase
    end

    // Overspeed run-length counter; any state change restarts the count.
    always_comb begin
        tf_cnt_nxt = tf_cnt;
        if (state_nxt != state) begin
            tf_cnt_nxt = 4'd0;
        end else if (ovs_active && vld) begin
            tf_cnt_nxt = too_fast ? tf_cnt + 4'd1 : 4'd0;
        end
    end

    // State and registered outputs; pwr_up drops in FAULT once the scale is at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= OFF;
            tf_cnt    <= 4'd0;
            fault     <= 1'b0;
            pwr_up    <= 1'b0;
            ramp_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            tf_cnt    <= tf_cnt_nxt;
            fault     <= (state_nxt == FAULT);
            ramp_done <= (state_nxt == RUN);
            pwr_up    <= (state_nxt == FAULT) ? (ss_nxt != 8'd0) : (state_nxt != OFF);
        end
    end

endmodule

// File: tb/tb_segway_pwr_seq.sv
// Scenario bench for segway_pwr_seq (SS_DIV=4, TF_CNT=3). Expected output
// snapshots are queued when stimulus is driven and popped when sampled.
module tb_segway_pwr_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       pwr_req;
    logic       vld;
    logic       too_fast;
    logic       en_steer_in;
    logic [7:0] ss_tmr;
    logic       pwr_up;
    logic       en_steer;
    logic       fault;
    logic       ramp_done;

    typedef struct {
        string       name;
        logic [11:0] v;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          total = 0;
    int          bad   = 0;
    logic [11:0] outs;

    assign outs = {ss_tmr, pwr_up, fault, ramp_done, en_steer};

    segway_pwr_seq #(
        .SS_DIV (4),
        .TF_CNT (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pwr_req     (pwr_req),
        .vld         (vld),
        .too_fast    (too_fast),
        .en_steer_in (en_steer_in),
        .ss_tmr      (ss_tmr),
        .pwr_up      (pwr_up),
        .en_steer    (en_steer),
        .fault       (fault),
        .ramp_done   (ramp_done)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] pk(input logic [7:0] ss, input logic pu, input logic f,
                                       input logic rd, input logic es);
        return {ss, pu, f, rd, es};
    endfunction

    task automatic want(input string name, input logic [11:0] v);
        exp_t x;
        x.name = name;
        x.v    = v;
        sb.push_back(x);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rst_pulse();
        rst = 1'b1; pwr_req = 1'b0; vld = 1'b0; too_fast = 1'b0; en_steer_in = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; pwr_req = 1'b0; vld = 1'b0; too_fast = 1'b0; en_steer_in = 1'b1;
        want("reset_state", pk(8'd0, 0, 0, 0, 0));
        tick(2);
        e = sb.pop_front(); total++;
        if (outs !== e.v) begin bad++; $display("FAIL %s: got ss=%0d pu/f/rd/es=%b want ss=%0d pu/f/rd/es=%b", e.name, outs[11:4], outs[3:0], e.v[11:4], e.v[3:0]); end
        rst = 1'b0;
    endtask

    task automatic test_ramp_up();
        pwr_req = 1'b1; vld = 1'b0;
        want("ramp_enter", pk(8'd0, 1, 0, 0, 0));
        tick(1);
        e = sb.pop_front(); total++;
        if (outs !== e.v) begin bad++; $display("FAIL %s: got ss=%0d pu/f/rd/es=%b want ss=%0d pu/f/rd/es=%b", e.name, outs[11:4], outs[3:0], e.v[11:4], e.v[3:0]); end
        vld = 1'b1;
        want("ramp_3vld", pk(8'd0, 1, 0, 0, 0));
        tick(3);
        e = sb.pop_front(); total++;
        if (outs !== e.v) begin bad++; $display("FAIL %s: got ss=%0d pu/f/rd/es=%b want ss=%0d pu/f/rd/es=%b", e.name, outs[11:4], outs[3:0], e.v[11:4], e.v[3:0]); end
        want("ramp_4vld", pk(8'd1, 1, 0, 0, 0));
        tick(1);
        e = sb.pop_front(); total++;
        if (outs !== e.v) begin bad++; $display("FAIL %s: got ss=%0d pu/f/rd/es=%b want ss=%0d pu/f/rd/es=%b", e.name, outs[11:4], outs[3:0], e.v[11:4], e.v[3:0]); end
        want("ramp_1019vld", pk(8'd254, 1, 0, 0, 0));
        tick(1015);
        e = sb.pop_front(); total++;
        if (outs !== e.v) begin bad++; $display("FAIL %s: got ss=%0d pu/f/rd/es=%b want ss=%0d pu/f/rd/es=%b", e.name, outs[11:4], outs[3:0], e.v[11:4], e.v[3:0]); end
        want("run_1020vld", pk(8'd255, 1, 0, 1, 1));
        tick(1);
        e = sb.pop_front(); total++;
        if (outs !== e.v) begin bad++; $display("FAIL %s: got ss=%0d pu/f/rd/es=%b want ss=%0d pu/f/rd/es=%b", e.name, outs[11:4], outs[3:0], e.v[11:4], e.v[3:0]); end
        vld = 1'b0; pwr_req = 1'b0;
        want("run_to_stop", pk(8'd255, 1, 0, 0, 0));
        tick(1);
        e = sb.pop_front(); total++;
        if (outs !== e.v) begin bad++; $display("FAIL %s: got ss=%0d pu/f/rd/es=%b want ss=%0d pu/f/rd/es=%b", e.name, outs[11:4], outs[3:0], e.v[11:4], e.v[3:0]); end
        vld = 1'b1;
        want("stop_first_dec", pk(8'd254, 1, 0, 0, 0));
        tick(4);
        e = sb.pop_front(); total++;
        if (outs !== e.v) begin bad++; $display("FAIL %s: got ss=%0d pu/f/rd/es=%b want ss=%0d pu/f/rd/es=%b", e.name, outs[11:4], outs[3:0], e.v[11:4], e.v[3:0]); end
    endtask

    task automatic test_stop_resume();
        rst_pulse();
        pwr_req = 1'b1;
        tick(1);
        vld = 1'b1;
        tick(401);                       // ss=100, prescaler left at 1
        pwr_req = 1'b0;
        want("stop_at_100", pk(8'd100, 1, 0, 0, 0));
        tick(1);
        e = sb.pop_front(); total++;
        if (outs !== e.v) begin bad++; $display("FAIL %s: got ss=%0d pu/f/rd/es=%b want ss=%0d pu/f/rd/es=%b", e.name, outs[11:4], outs[3:0], e.v[11:4], e.v[3:0]); end
        want("stop_399vld", pk(8'd1, 1, 0, 0, 0));
        tick(399);
        e = sb.pop_front(); total++;
        if (outs !== e.v) begin bad++; $display("FAIL %s: got ss=%0d pu/f/rd/es=%b want ss=%0d pu/f/rd/es=%b", e.name, outs[11:4], outs[3:0], e.v[11:4], e.v[3:0]); end
        want("stop_to_off", pk(8'd0, 0, 0, 0, 0));
        tick(1);
        e = sb.pop_front(); total++;
        if (outs !== e.v) begin bad++; $display("FAIL %s: got ss=%0d pu/f/rd/es=%b want ss=%0d pu/f/rd/es=%b", e.name, outs[11:4], outs[3:0], e.v[11:4], e.v[3:0]); end
        pwr_req = 1'b1;
        tick(1);
        tick(401);                       // ss=100 again
        pwr_req = 1'b0;
        tick(1);
        want("stop_down_to_50", pk(8'd50, 1, 0, 0, 0));
        tick(202);                       // ss=50, prescaler left at 2
        e = sb.pop_front(); total++;
        if (outs !== e.v) begin bad++; $display("FAIL %s: got ss=%0d pu/f/rd/es=%b want ss=%0d pu/f/rd/es=%b", e.name, outs[11:4], outs[3:0], e.v[11:4], e.v[3:0]); end
        pwr_req = 1'b1;
        want("resume_ramp_50", pk(8'd50, 1, 0, 0, 0));
        tick(1);
        e = sb.pop_front(); total++;
        if (outs !== e.v) begin bad++; $display("FAIL %s: got ss=%0d pu/f/rd/es=%b want ss=%0d pu/f/rd/es=%b", e.name, outs[11:4], outs[3:0], e.v[11:4], e.v[3:0]); end
        want("resume_3vld", pk(8'd50, 1, 0, 0, 0));
        tick(3);
        e = sb.pop_front(); total++;
        if (outs !== e.v) begin bad++; $display("FAIL %s: got ss=%0d pu/f/rd/es=%b want ss=%0d pu/f/rd/es=%b", e.name, outs[11:4], outs[3:0], e.v[11:4], e.v[3:0]); end
        want("resume_4vld", pk(8'd51, 1, 0, 0, 0));
        tick(1);
        e = sb.pop_front(); total++;
        if (outs !== e.v) begin bad++; $display("FAIL %s: got ss=%0d pu/f/rd/es=%b want ss=%0d pu/f/rd/es=%b", e.name, outs[11:4], outs[3:0], e.v[11:4], e.v[3:0]); end
    endtask

    task automatic test_overspeed();
        rst_pulse();
        pwr_req = 1'b1;
        tick(1);
        vld = 1'b1;
        want("os_run", pk(8'd255, 1, 0, 1, 1));
        tick(1020);
        e = sb.pop_front(); total++;
        if (outs !== e.v) begin bad++; $display("FAIL %s: got ss=%0d pu/f/rd/es=%b want ss=%0d pu/f/rd/es=%b", e.name, outs[11:4], outs[3:0], e.v[11:4], e.v[3:0]); end
        vld = 1'b0; en_steer_in = 1'b0;
        want("os_steer_gate", pk(8'd255, 1, 0, 1, 0));
        tick(1);
        e = sb.pop_front(); total++;
        if (outs !== e.v) begin bad++; $display("FAIL %s: got ss=%0d pu/f/rd/es=%b want ss=%0d pu/f/rd/es=%b", e.name, outs[11:4], outs[3:0], e.v[11:4], e.v[3:0]); end
        en_steer_in = 1'b1;
        vld = 1'b1; too_fast = 1'b1;
        want("os_pair", pk(8'd255, 1, 0, 1, 1));
        tick(2);
        e = sb.pop_front(); total++;
        if (outs !== e.v) begin bad++; $display("FAIL %s: got ss=%0d pu/f/rd/es=%b want ss=%0d pu/f/rd/es=%b", e.name, outs[11:4], outs[3:0], e.v[11:4], e.v[3:0]); end
        vld = 1'b0;
        want("os_no_vld_ignored", pk(8'd255, 1, 0, 1, 1));
        tick(3);
        e = sb.pop_front(); total++;
        if (outs !== e.v) begin bad++; $display("FAIL %s: got ss=%0d pu/f/rd/es=%b want ss=%0d pu/f/rd/es=%b", e.name, outs[11:4], outs[3:0], e.v[11:4], e.v[3:0]); end
        vld = 1'b1; too_fast = 1'b0;
        tick(1);
        too_fast = 1'b1;
        want("os_two_after_clear", pk(8'd255, 1, 0, 1, 1));
        tick(2);
        e = sb.pop_front(); total++;
        if (outs !== e.v) begin bad++; $display("FAIL %s: got ss=%0d pu/f/rd/es=%b want ss=%0d pu/f/rd/es=%b", e.name, outs[11:4], outs[3:0], e.v[11:4], e.v[3:0]); end
        pwr_req = 1'b0;                  // trip must win over the release
        want("os_trip", pk(8'd255, 1, 1, 0, 0));
        tick(1);
        e = sb.pop_front(); total++;
        if (outs !== e.v) begin bad++; $display("FAIL %s: got ss=%0d pu/f/rd/es=%b want ss=%0d pu/f/rd/es=%b", e.name, outs[11:4], outs[3:0], e.v[11:4], e.v[3:0]); end
        too_fast = 1'b0;
        want("fault_ramp_down", pk(8'd1, 1, 1, 0, 0));
        tick(1019);
        e = sb.pop_front(); total++;
        if (outs !== e.v) begin bad++; $display("FAIL %s: got ss=%0d pu/f/rd/es=%b want ss=%0d pu/f/rd/es=%b", e.name, outs[11:4], outs[3:0], e.v[11:4], e.v[3:0]); end
        want("fault_at_zero", pk(8'd0, 0, 1, 0, 0));
        tick(1);
        e = sb.pop_front(); total++;
        if (outs !== e.v) begin bad++; $display("FAIL %s: got ss=%0d pu/f/rd/es=%b want ss=%0d pu/f/rd/es=%b", e.name, outs[11:4], outs[3:0], e.v[11:4], e.v[3:0]); end
        want("fault_exit_off", pk(8'd0, 0, 0, 0, 0));
        tick(1);
        e = sb.pop_front(); total++;
        if (outs !== e.v) begin bad++; $display("FAIL %s: got ss=%0d pu/f/rd/es=%b want ss=%0d pu/f/rd/es=%b", e.name, outs[11:4], outs[3:0], e.v[11:4], e.v[3:0]); end
    endtask

    task automatic test_trip_on_tick();
        rst_pulse();
        pwr_req = 1'b1;
        tick(1);
        vld = 1'b1;
        want("tick_ss10", pk(8'd10, 1, 0, 0, 0));
        tick(40);
        e = sb.pop_front(); total++;
        if (outs !== e.v) begin bad++; $display("FAIL %s: got ss=%0d pu/f/rd/es=%b want ss=%0d pu/f/rd/es=%b", e.name, outs[11:4], outs[3:0], e.v[11:4], e.v[3:0]); end
        tick(1);                         // prescaler 1
        too_fast = 1'b1;
        want("tick_pre3", pk(8'd10, 1, 0, 0, 0));
        tick(2);                         // prescaler 3, tf_cnt 2
        e = sb.pop_front(); total++;
        if (outs !== e.v) begin bad++; $display("FAIL %s: got ss=%0d pu/f/rd/es=%b want ss=%0d pu/f/rd/es=%b", e.name, outs[11:4], outs[3:0], e.v[11:4], e.v[3:0]); end
        want("tick_trip_holds_ss", pk(8'd10, 1, 1, 0, 0));
        tick(1);
        e = sb.pop_front(); total++;
        if (outs !== e.v) begin bad++; $display("FAIL %s: got ss=%0d pu/f/rd/es=%b want ss=%0d pu/f/rd/es=%b", e.name, outs[11:4], outs[3:0], e.v[11:4], e.v[3:0]); end
        too_fast = 1'b0;
        want("tick_fault_ss1", pk(8'd1, 1, 1, 0, 0));
        tick(39);
        e = sb.pop_front(); total++;
        if (outs !== e.v) begin bad++; $display("FAIL %s: got ss=%0d pu/f/rd/es=%b want ss=%0d pu/f/rd/es=%b", e.name, outs[11:4], outs[3:0], e.v[11:4], e.v[3:0]); end
        want("tick_fault_hold_req", pk(8'd0, 0, 1, 0, 0));
        tick(6);
        e = sb.pop_front(); total++;
        if (outs !== e.v) begin bad++; $display("FAIL %s: got ss=%0d pu/f/rd/es=%b want ss=%0d pu/f/rd/es=%b", e.name, outs[11:4], outs[3:0], e.v[11:4], e.v[3:0]); end
        pwr_req = 1'b0;
        want("tick_release_off", pk(8'd0, 0, 0, 0, 0));
        tick(1);
        e = sb.pop_front(); total++;
        if (outs !== e.v) begin bad++; $display("FAIL %s: got ss=%0d pu/f/rd/es=%b want ss=%0d pu/f/rd/es=%b", e.name, outs[11:4], outs[3:0], e.v[11:4], e.v[3:0]); end
    endtask

    task automatic test_reset_mid_ramp();
        rst_pulse();
        pwr_req = 1'b1;
        tick(1);
        vld = 1'b1;
        tick(308);                       // ss=77
        too_fast = 1'b1;
        want("mid_ss77_tf2", pk(8'd77, 1, 0, 0, 0));
        tick(2);
        e = sb.pop_front(); total++;
        if (outs !== e.v) begin bad++; $display("FAIL %s: got ss=%0d pu/f/rd/es=%b want ss=%0d pu/f/rd/es=%b", e.name, outs[11:4], outs[3:0], e.v[11:4], e.v[3:0]); end
        rst = 1'b1;
        want("mid_reset", pk(8'd0, 0, 0, 0, 0));
        tick(1);
        e = sb.pop_front(); total++;
        if (outs !== e.v) begin bad++; $display("FAIL %s: got ss=%0d pu/f/rd/es=%b want ss=%0d pu/f/rd/es=%b", e.name, outs[11:4], outs[3:0], e.v[11:4], e.v[3:0]); end
        rst = 1'b0;
        want("mid_reramp", pk(8'd0, 1, 0, 0, 0));
        tick(1);
        e = sb.pop_front(); total++;
        if (outs !== e.v) begin bad++; $display("FAIL %s: got ss=%0d pu/f/rd/es=%b want ss=%0d pu/f/rd/es=%b", e.name, outs[11:4], outs[3:0], e.v[11:4], e.v[3:0]); end
        want("mid_two_no_trip", pk(8'd0, 1, 0, 0, 0));
        tick(2);
        e = sb.pop_front(); total++;
        if (outs !== e.v) begin bad++; $display("FAIL %s: got ss=%0d pu/f/rd/es=%b want ss=%0d pu/f/rd/es=%b", e.name, outs[11:4], outs[3:0], e.v[11:4], e.v[3:0]); end
        want("mid_full_run_trip", pk(8'd0, 0, 1, 0, 0));
        tick(1);
        e = sb.pop_front(); total++;
        if (outs !== e.v) begin bad++; $display("FAIL %s: got ss=%0d pu/f/rd/es=%b want ss=%0d pu/f/rd/es=%b", e.name, outs[11:4], outs[3:0], e.v[11:4], e.v[3:0]); end
        too_fast = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pwr_req = 1'b0; vld = 1'b0; too_fast = 1'b0; en_steer_in = 1'b1;
        test_reset();
        test_ramp_up();
        test_stop_resume();
        test_overspeed();
        test_trip_on_tick();
        test_reset_mid_ramp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/segway_pwr_seq.md
Name: segway_pwr_seq

Overview:
- Power/soft-start sequencer that drives the control inputs of the Segway motor-math datapath: ss_tmr, pwr_up and the gated en_steer.
- Ramps the soft-start scale up on rider power request and ramps it down on release.
- Watches the datapath's too_fast flag and forces a latched soft-stop fault.
- Sits between the PID/inertial update strobe and the motor-math block.

Parameters:
- SS_DIV, 4, number of vld strobes per 1-LSB ss_tmr step (legal range 1..16).
- TF_CNT, 3, consecutive vld samples with too_fast=1 needed to trip a fault (legal range 1..15).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- pwr_req  in  1  rider/power request level.
- vld  in  1  single-cycle PID update strobe; all sequencing advances only on vld.
- too_fast  in  1  overspeed flag from the motor-math datapath.
- en_steer_in  in  1  steering-enable request from the steering-enable logic.
- ss_tmr  out  8  soft-start scale to the datapath; 0 = no torque, 255 = full.
- pwr_up  out  1  datapath power enable.
- en_steer  out  1  gated steering enable to the datapath.
- fault  out  1  latched overspeed fault.
- ramp_done  out  1  high while in RUN.

Behaviour:
- One clock; reset is synchronous and active-high.
- rst (any state, mid-ramp included) forces next edge: state=OFF, ss_tmr=0, pwr_up=0, fault=0, prescaler=0, tf_cnt=0.
- All outputs are registered except en_steer, which is en_steer_in AND (state==RUN).
- States: OFF, RAMP, RUN, STOP, FAULT.
- OFF:
  - ss_tmr=0, pwr_up=0.
  - pwr_req=1 → RAMP on the next edge (no vld needed).
- RAMP (pwr_up=1):
  - Each vld increments the prescaler.
  - On the SS_DIV-th vld: prescaler→0 and ss_tmr+=1, saturating at 255.
  - Enter RUN on the edge where ss_tmr becomes 255.
  - pwr_req=0 → STOP; ss_tmr is held, prescaler is cleared.
- RUN (pwr_up=1, ss_tmr=255, ramp_done=1):
  - pwr_req=0 → STOP.
- STOP (pwr_up=1):
  - Same prescaler, but ss_tmr decrements and saturates at 0.
  - Reaching 0 → OFF.
  - pwr_req=1 → RAMP, resuming from the current ss_tmr value with the prescaler cleared.
- FAULT (pwr_up=1 while ss_tmr>0, fault=1):
  - Decrements ss_tmr like STOP.
  - pwr_req is ignored for re-ramp.
  - Leave to OFF only when ss_tmr==0 and pwr_req==0; fault clears on that edge.
  - While ss_tmr==0 and pwr_req==1: stay in FAULT with pwr_up=0.
- Overspeed counter tf_cnt (4 bits), active in RAMP and RUN only:
  - vld with too_fast=1 → tf_cnt+1.
  - vld with too_fast=0 → tf_cnt=0.
  - tf_cnt reaching TF_CNT → FAULT on that same edge, tf_cnt=0.
  - Cleared on every state change.
  - too_fast without vld is ignored.
- Priority on the same vld:
  - Fault trip beats ss_tmr step; ss_tmr is not incremented on the tripping edge.
  - Fault trip beats pwr_req=0.
- Prescaler:
  - Width is ceil(log2(SS_DIV)).
  - Cleared on every state transition.
  - SS_DIV=1 steps on every vld.
- Non-vld cycles change only state transitions triggered by pwr_req or rst; ss_tmr never changes without vld.

Decomposition:
- Package segway_pkg holds:
  - state enum seq_state_t {OFF, RAMP, RUN, STOP, FAULT}.
  - SS_MAX=8'hFF.
  - Default SS_DIV and TF_CNT constants.
- One natural sub-module, ss_ramp_cnt: prescaler plus saturating up/down 8-bit counter, with inputs vld, up, dn, clr_pre. The FSM and overspeed counter stay in the top.

Test Plan:
- Reset then pwr_req=1 with continuous vld, SS_DIV=4 → RAMP next edge; ss_tmr=1 after 4th vld; ss_tmr=255 and RUN/ramp_done=1 after 1020th vld.
- At ss_tmr=100 in RAMP, drop pwr_req → STOP; 400 vld later ss_tmr=0, OFF, pwr_up=0. Reassert pwr_req at ss_tmr=50 → RAMP resumes from 50.
- In RUN, too_fast=1 on 2 vld, then 0 on 1 vld, then 1 on 3 vld → no fault after the first pair; FAULT with fault=1 on the 3rd consecutive vld.
- Trip on the same vld as the 4th prescaler tick at ss_tmr=10 in RAMP → ss_tmr stays 10 and state=FAULT. Hold pwr_req=1 → ss_tmr reaches 0, pwr_up=0, fault stays 1. Drop pwr_req → OFF, fault=0.
- en_steer_in=1 throughout → en_steer=0 in OFF/RAMP/STOP/FAULT and 1 only in RUN.
- Assert rst mid-ramp at ss_tmr=77 with tf_cnt=2 → next edge all outputs 0, state OFF. A subsequent trip needs a full TF_CNT run.
